// File: rtl/multicycle_main_fsm.sv
// Main sequencer for the multicycle RV32I core: walks the shared ALU and unified
// memory port through fetch/decode/execute/memory/writeback with a memory ready stall.
module multicycle_main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               RegWrite,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state_q;
  state_t state_d;

  logic pcupdate;
  logic branch;
  logic memwrite_c;
  logic regwrite_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = FETCH;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pcupdate  = mem_ready;
        if (mem_ready) state_d = DECODE;
        else           state_d = FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OP_LW) state_d = MEMREAD;
        else             state_d = MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = MEMWB;
        else           state_d = MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        regwrite_c = 1'b1;
      end
      // Write strobe stays up for the whole stall so slow memory sees a stable request.
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        memwrite_c = 1'b1;
        if (mem_ready) state_d = FETCH;
        else           state_d = MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        regwrite_c = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
        state_d  = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  // Architectural writes are masked while reset is high so nothing commits during reset.
  assign PCWrite  = ~reset & (pcupdate | (branch & zero));
  assign MemWrite = ~reset & memwrite_c;
  assign RegWrite = ~reset & regwrite_c;
  assign state    = state_q;

endmodule
